background_gen: RTL and testbench

Per-pixel background and wall compositor sitting directly downstream of the SPI register block: it consumes the live `sky`, `floor`, `leak` values and generates the `load_new` strobe that tells that block when buffered SPI values may go live. It takes the VGA beam position plus the per-column wall height and colour from the tracer, and produces the final registered 6-bit RGB pixel two clocks later. It also keeps a frame counter for downstream animation and debug.

---
 rtl/background_gen_pkg.sv | 22 ++
 rtl/vblank_strobe.sv | 52 +++++
 rtl/background_gen.sv | 115 +++++++++++
 tb/tb_background_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/background_gen_pkg.sv
// background_gen_pkg: shared widths, default view geometry and region codes for the
// background/wall compositor and its vblank strobe generator.
//   RGB_W       - pixel width, RRGGBB
//   POS_W       - beam coordinate width
//   *_DEF       - default visible geometry, shared with the VGA sync block
//   region_e    - stage-1 region code carried down the pixel pipeline
package background_gen_pkg;

  localparam int unsigned RGB_W = 6;
  localparam int unsigned POS_W = 10;

  localparam int unsigned H_VIEW_DEF = 640;
  localparam int unsigned V_VIEW_DEF = 480;
  localparam int unsigned HALF_DEF   = 240;

  typedef enum logic [1:0] {
    RegSky   = 2'd0,
    RegFloor = 2'd1,
    RegWall  = 2'd2
  } region_e;

endpackage

// File: rtl/vblank_strobe.sv
// vblank_strobe: detects entry into vertical blanking and emits a one-cycle load_new
// strobe, together with an 8-bit frame counter that steps on the same edge.
//   clk      in   pixel clock
//   reset_n  in   asynchronous active-low reset
//   v        in   beam row
//   load_new out  one-cycle strobe, high the cycle after v first reaches V_VIEW
//   frame    out  frame counter, wraps 255 -> 0
module vblank_strobe
  import background_gen_pkg::*;
#(
  parameter int unsigned V_VIEW = V_VIEW_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [POS_W-1:0] v,
  output logic             load_new,
  output logic [7:0]       frame
);

  localparam logic [POS_W-1:0] VView = POS_W'(V_VIEW);

  logic       in_vb_d;
  logic       in_vb_q;
  logic       enter_vb;
  logic       load_new_q;
  logic [7:0] frame_q;

  always_comb begin
    in_vb_d  = (v >= VView);
    // Edge against the registered flag, so a stalled or jumping v fires only once.
    enter_vb = in_vb_d & ~in_vb_q;
  end

  // in_vb resets high so a reset taken inside vblank cannot produce a strobe on release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_vb_q    <= 1'b1;
      load_new_q <= 1'b0;
      frame_q    <= 8'd0;
    end else begin
      in_vb_q    <= in_vb_d;
      load_new_q <= enter_vb;
      if (enter_vb) begin
        frame_q <= frame_q + 8'd1;
      end
    end
  end

  assign load_new = load_new_q;
  assign frame    = frame_q;

endmodule

// File: rtl/background_gen.sv
// background_gen: two-stage per-pixel compositor producing sky, floor or wall colour.
// Stage 1 registers visibility, region code and wall colour; stage 2 registers rgb,
// picking the live sky/floor colours at that point.
//   clk       in   pixel clock, one pixel per cycle
//   reset_n   in   asynchronous active-low reset (release already synchronised upstream)
//   h, v      in   beam column / row
//   sky       in   sky colour
//   floor     in   floor colour
//   leak      in   rows of floor raised above the horizon
//   wall_h    in   wall half-height for column h
//   wall_rgb  in   wall colour for column h
//   rgb       out  final registered pixel, 2 cycles after inputs
//   load_new  out  one-cycle strobe on vblank entry
//   frame     out  frame counter
module background_gen
  import background_gen_pkg::*;
#(
  parameter int unsigned H_VIEW = H_VIEW_DEF,
  parameter int unsigned V_VIEW = V_VIEW_DEF,
  parameter int unsigned HALF   = HALF_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [POS_W-1:0] h,
  input  logic [POS_W-1:0] v,
  input  logic [RGB_W-1:0] sky,
  input  logic [RGB_W-1:0] floor,
  input  logic [5:0]       leak,
  input  logic [POS_W-1:0] wall_h,
  input  logic [RGB_W-1:0] wall_rgb,
  output logic [RGB_W-1:0] rgb,
  output logic             load_new,
  output logic [7:0]       frame
);

  localparam logic [POS_W-1:0] HView  = POS_W'(H_VIEW);
  localparam logic [POS_W-1:0] VView  = POS_W'(V_VIEW);
  localparam logic [POS_W-1:0] Half   = POS_W'(HALF);
  localparam logic [POS_W:0]   HalfX  = (POS_W + 1)'(HALF);

  logic             vis_d;
  logic [POS_W-1:0] fb;
  logic [POS_W:0]   v_x;
  logic [POS_W:0]   wh_x;
  region_e          region_d;

  logic             vis_q;
  region_e          region_q;
  logic [RGB_W-1:0] wall_rgb_q;

  logic [RGB_W-1:0] rgb_d;
  logic [RGB_W-1:0] rgb_q;

  always_comb begin
    vis_d = (h < HView) && (v < VView);
    // leak <= 63 < HALF, so the floor boundary never underflows.
    fb    = Half - {{(POS_W - 6){1'b0}}, leak};
    // One extra bit keeps v + wall_h and HALF + wall_h from wrapping.
    v_x   = {1'b0, v};
    wh_x  = {1'b0, wall_h};
    if ((v_x + wh_x >= HalfX) && (v_x < HalfX + wh_x)) begin
      region_d = RegWall;
    end else if (v >= fb) begin
      region_d = RegFloor;
    end else begin
      region_d = RegSky;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vis_q      <= 1'b0;
      region_q   <= RegSky;
      wall_rgb_q <= '0;
    end else begin
      vis_q      <= vis_d;
      region_q   <= region_d;
      wall_rgb_q <= wall_rgb;
    end
  end

  // sky/floor are taken live here; they only change in vblank so no tearing results.
  always_comb begin
    rgb_d = '0;
    if (vis_q) begin
      case (region_q)
        RegSky:   rgb_d = sky;
        RegFloor: rgb_d = floor;
        RegWall:  rgb_d = wall_rgb_q;
        default:  rgb_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb = rgb_q;

  vblank_strobe #(
    .V_VIEW (V_VIEW)
  ) u_vblank_strobe (
    .clk      (clk),
    .reset_n  (reset_n),
    .v        (v),
    .load_new (load_new),
    .frame    (frame)
  );

endmodule

// File: tb/tb_background_gen.sv
// tb_background_gen: scoreboard bench for background_gen. The driver pushes the
// expected pixel (due two cycles later) and expected strobes into queues; a monitor on
// the falling edge pops and compares rgb, load_new and frame.
module tb_background_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [9:0] h = '0;
  logic [9:0] v = '0;
  logic [9:0] wall_h = '0;
  logic [5:0] sky = '0;
  logic [5:0] floor_c = '0;
  logic [5:0] leak = '0;
  logic [5:0] wall_rgb = '0;
  logic [5:0] rgb;
  logic       load_new;
  logic [7:0] frame;

  background_gen dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .h        (h),
    .v        (v),
    .sky      (sky),
    .floor    (floor_c),
    .leak     (leak),
    .wall_h   (wall_h),
    .wall_rgb (wall_rgb),
    .rgb      (rgb),
    .load_new (load_new),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [5:0] exp;
    int         tag;
  } pix_t;

  pix_t       pix_q[$];
  int         strobe_q[$];
  logic [7:0] frame_exp = 8'd0;
  bit         armed = 1'b0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference pixel from the geometric rules, using signed arithmetic.
  function automatic logic [5:0] model(input int hh, input int vv, input int lk, input int wh,
                                       input logic [5:0] wr, input logic [5:0] sk,
                                       input logic [5:0] fl);
    if (hh >= 640 || vv >= 480) return 6'd0;
    if (wh > 0 && vv >= 240 - wh && vv < 240 + wh) return wr;
    if (vv >= 240 - lk) return fl;
    return sk;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int hh, input int vv, input int lk, input int wh,
                       input logic [5:0] wr, input bit use_exp, input logic [5:0] exp_in,
                       input int tag);
    pix_t p;
    h        = 10'(hh);
    v        = 10'(vv);
    leak     = 6'(lk);
    wall_h   = 10'(wh);
    wall_rgb = wr;
    p.due    = cyc + 2;
    p.exp    = use_exp ? exp_in : model(hh, vv, lk, wh, wr, sky, floor_c);
    p.tag    = tag;
    pix_q.push_back(p);
    // A strobe is owed the first time v reaches vblank after a visible row was seen.
    if (vv >= 480) begin
      if (armed) begin
        strobe_q.push_back(cyc + 1);
        armed = 1'b0;
      end
    end else begin
      armed = 1'b1;
    end
    step();
  endtask

  task automatic set_bg(input logic [5:0] sk, input logic [5:0] fl);
    drive(700, 0, 0, 0, 6'd0, 1'b1, 6'd0, 0);
    drive(700, 0, 0, 0, 6'd0, 1'b1, 6'd0, 0);
    sky     = sk;
    floor_c = fl;
    drive(700, 0, 0, 0, 6'd0, 1'b1, 6'd0, 0);
  endtask

  always @(negedge clk) begin
    pix_t p;
    bit   exp_ln;
    while (pix_q.size() > 0 && pix_q[0].due < cyc) begin
      p = pix_q.pop_front();
      total++;
      bad++;
      $display("FAIL rgb_missed#%0d: no sample taken, required %0h", p.tag, p.exp);
    end
    if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
      p = pix_q.pop_front();
      check($sformatf("rgb#%0d", p.tag), rgb, p.exp);
    end
    exp_ln = 1'b0;
    if (strobe_q.size() > 0 && strobe_q[0] == cyc) begin
      void'(strobe_q.pop_front());
      exp_ln    = 1'b1;
      frame_exp = frame_exp + 8'd1;
    end
    check("load_new", load_new, exp_ln);
    check("frame", frame, frame_exp);
  end

  initial begin
    int n;
    #1 reset_n = 1'b0;
    #1;
    check("reset_rgb", rgb, 0);
    check("reset_load_new", load_new, 0);
    check("reset_frame", frame, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Region selection
    set_bg(6'b010101, 6'b101010);
    drive(100, 239, 0, 0, 6'd0, 1'b1, 6'b010101, 1);
    drive(100, 240, 0, 0, 6'd0, 1'b1, 6'b101010, 2);
    // Leak
    drive(100, 229, 10, 0, 6'd0, 1'b1, 6'b010101, 3);
    drive(100, 230, 10, 0, 6'd0, 1'b1, 6'b101010, 4);
    drive(100, 177, 63, 0, 6'd0, 1'b1, 6'b101010, 5);
    drive(100, 176, 63, 0, 6'd0, 1'b1, 6'b010101, 6);
    // Wall
    drive(100, 219, 0, 20, 6'b110000, 1'b1, 6'b010101, 7);
    drive(100, 220, 0, 20, 6'b110000, 1'b1, 6'b110000, 8);
    drive(100, 259, 0, 20, 6'b110000, 1'b1, 6'b110000, 9);
    drive(100, 260, 0, 20, 6'b110000, 1'b1, 6'b101010, 10);
    drive(5, 0, 0, 300, 6'b001100, 1'b1, 6'b001100, 11);
    drive(5, 479, 0, 300, 6'b001111, 1'b1, 6'b001111, 12);
    // Blanking
    drive(640, 100, 0, 300, 6'b111111, 1'b1, 6'd0, 13);
    drive(100, 480, 0, 300, 6'b111111, 1'b1, 6'd0, 14);
    drive(639, 479, 0, 0, 6'b111111, 1'b1, 6'b101010, 15);

    // Three frames of random pixels, colours changed only deep in vblank
    for (int f = 0; f < 3; f++) begin
      for (int vv = 0; vv < 525; vv++) begin
        if (vv == 490) begin
          sky     = 6'($urandom());
          floor_c = 6'($urandom());
        end
        drive($urandom_range(0, 799), vv, $urandom_range(0, 63), $urandom_range(0, 300),
              6'($urandom()), 1'b0, 6'd0, 100 + f);
      end
    end

    // Short frames to walk the counter through its wrap
    for (int f = 0; f < 260; f++) begin
      drive($urandom_range(0, 799), 100, $urandom_range(0, 63), $urandom_range(0, 60),
            6'($urandom()), 1'b0, 6'd0, 200);
      drive($urandom_range(0, 799), 479, $urandom_range(0, 63), $urandom_range(0, 300),
            6'($urandom()), 1'b0, 6'd0, 201);
      drive($urandom_range(0, 799), 480, 0, 0, 6'd0, 1'b0, 6'd0, 202);
      drive($urandom_range(0, 799), 500, 0, 0, 6'd0, 1'b0, 6'd0, 203);
    end

    // Mid-line reset
    set_bg(6'b010101, 6'b101010);
    drive(100, 100, 0, 0, 6'd0, 1'b1, 6'b010101, 300);
    repeat (3) step();
    pix_q.delete();
    #2 reset_n = 1'b0;
    frame_exp = 8'd0;
    strobe_q.delete();
    armed = 1'b0;
    #1;
    check("async_rgb", rgb, 0);
    check("async_load_new", load_new, 0);
    check("async_frame", frame, 0);
    repeat (3) begin
      step();
      check("rst_rgb", rgb, 0);
    end
    #2 reset_n = 1'b1;
    armed = 1'b1;
    step();
    check("release_rgb0", rgb, 0);
    step();
    check("release_rgb1", rgb, 6'b010101);

    // Reset inside vblank
    for (int vv = 470; vv <= 500; vv++) begin
      drive(100, vv, 0, 0, 6'd0, 1'b0, 6'd0, 400);
    end
    pix_q.delete();
    #2 reset_n = 1'b0;
    frame_exp = 8'd0;
    strobe_q.delete();
    armed = 1'b0;
    #1;
    check("vb_async_frame", frame, 0);
    check("vb_async_rgb", rgb, 0);
    for (int vv = 501; vv < 510; vv++) begin
      v = 10'(vv);
      step();
      check("vb_rst_rgb", rgb, 0);
    end
    v = 10'd510;
    #2 reset_n = 1'b1;
    step();
    for (int vv = 511; vv < 525; vv++) begin
      drive($urandom_range(0, 799), vv, 0, 0, 6'd0, 1'b0, 6'd0, 500);
    end
    for (int vv = 0; vv < 486; vv++) begin
      drive($urandom_range(0, 799), vv, $urandom_range(0, 63), $urandom_range(0, 300),
            6'($urandom()), 1'b0, 6'd0, 501);
    end

    n = 0;
    while (pix_q.size() > 0 || strobe_q.size() > 0) begin
      if (n == 10) begin
        total++;
        bad++;
        $display("FAIL drain: %0d pixels and %0d strobes still pending, required 0",
                 pix_q.size(), strobe_q.size());
        break;
      end
      step();
      n++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
